reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer_if.sv | 20 ++
 rtl/reset_sequencer.sv | 168 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between reset_sequencer (master) and the downstream stages it releases (slave).
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_reset_n;
  logic                  all_ready;
  logic                  fault;
  logic [2:0]            seq_state;

  modport master (
    input  stage_ready,
    output stage_reset_n, all_ready, fault, seq_state
  );

  modport slave (
    output stage_ready,
    input  stage_reset_n, all_ready, fault, seq_state
  );
endinterface

// File: rtl/reset_sequencer.sv
// Sequenced release of NUM_STAGES downstream resets with ready handshakes and timeout fault.
// Optional macro RESET_SEQ_RETRY_EN: retry the whole sequence up to three times on ack timeout.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int SYNC_DEPTH  = 2,
  parameter int TICK_DIV    = 100000,
  parameter int HOLD_TICKS  = 10,
  parameter int ACK_TIMEOUT = 50
) (
  input  logic              clk,
  input  logic              reset,
  reset_sequencer_if.master seq
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int TC_MAX = (HOLD_TICKS > ACK_TIMEOUT) ? HOLD_TICKS : ACK_TIMEOUT;
  localparam int TC_W   = (TC_MAX > 1) ? $clog2(TC_MAX) : 1;
  localparam int K_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [TC_W-1:0]  HOLD_LAST = TC_W'(HOLD_TICKS - 1);
  localparam logic [TC_W-1:0]  ACK_LAST  = TC_W'(ACK_TIMEOUT - 1);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_ASSERT   = 3'd0,
    ST_HOLD     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_RUN      = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_DEPTH-1:0]   sync_q;
  logic [DIV_W-1:0]        divCnt_q;
  logic [TC_W-1:0]         tickCnt_q;
  logic [K_W-1:0]          stageIdx_q, stageIdx_d;
  logic [NUM_STAGES-1:0]   stageRstN_q, stageRstN_d;
  logic                    allReady_q, allReady_d;
  logic                    fault_q, fault_d;
  logic                    syncOut;
  logic                    tick;
  logic                    stateEnter;
`ifdef RESET_SEQ_RETRY_EN
  logic [1:0]              retryCnt_q, retryCnt_d;
`endif

  assign syncOut    = sync_q[SYNC_DEPTH-1];
  assign tick       = (divCnt_q == DIV_LAST);
  assign stateEnter = (state_d != state_q);

  // Reset assertion is asynchronous; only its release is retimed through the shift chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_ASSERT;
      divCnt_q    <= '0;
      tickCnt_q   <= '0;
      stageIdx_q  <= '0;
      stageRstN_q <= '0;
      allReady_q  <= 1'b0;
      fault_q     <= 1'b0;
`ifdef RESET_SEQ_RETRY_EN
      retryCnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stageIdx_q  <= stageIdx_d;
      stageRstN_q <= stageRstN_d;
      allReady_q  <= allReady_d;
      fault_q     <= fault_d;
`ifdef RESET_SEQ_RETRY_EN
      retryCnt_q  <= retryCnt_d;
`endif
      // Tick timing restarts on every state entry so hold/timeout windows are exact.
      if (stateEnter) begin
        divCnt_q  <= '0;
        tickCnt_q <= '0;
      end else begin
        divCnt_q <= tick ? '0 : divCnt_q + DIV_W'(1);
        if (tick && (state_q == ST_HOLD || state_q == ST_WAIT_ACK)) begin
          tickCnt_q <= tickCnt_q + TC_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    stageIdx_d  = stageIdx_q;
    stageRstN_d = stageRstN_q;
    allReady_d  = allReady_q;
    fault_d     = fault_q;
`ifdef RESET_SEQ_RETRY_EN
    retryCnt_d  = retryCnt_q;
`endif
    case (state_q)
      ST_ASSERT: begin
        if (syncOut) begin
          state_d    = ST_HOLD;
          stageIdx_d = '0;
        end
      end
      ST_HOLD: begin
        if (tick && tickCnt_q == HOLD_LAST) begin
          stageRstN_d[stageIdx_q] = 1'b1;
          state_d                 = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // Ready is checked before the timeout so a same-edge ack still counts.
        if (seq.stage_ready[stageIdx_q]) begin
          if (stageIdx_q == K_LAST) begin
            state_d    = ST_RUN;
            allReady_d = &seq.stage_ready;
          end else begin
            stageIdx_d = stageIdx_q + K_W'(1);
            state_d    = ST_HOLD;
          end
        end else if (tick && tickCnt_q == ACK_LAST) begin
`ifdef RESET_SEQ_RETRY_EN
          if (retryCnt_q != 2'd3) begin
            retryCnt_d  = retryCnt_q + 2'd1;
            stageRstN_d = '0;
            stageIdx_d  = '0;
            state_d     = ST_HOLD;
          end else begin
            state_d = ST_FAULT;
          end
`else
          state_d = ST_FAULT;
`endif
        end
      end
      ST_RUN: begin
        allReady_d = &seq.stage_ready;
        if (!(&seq.stage_ready)) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    if (state_d == ST_FAULT) begin
      stageRstN_d = '0;
      allReady_d  = 1'b0;
      fault_d     = 1'b1;
    end
  end

  assign seq.stage_reset_n = stageRstN_q;
  assign seq.all_ready     = allReady_q;
  assign seq.fault         = fault_q;
  assign seq.seq_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed and $urandom ack-delay scenarios checked per edge against
// an event-timeline model; tracks RESET_SEQ_RETRY_EN when that macro is defined.
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int NS       = 3;
  localparam int SD       = 2;
  localparam int TD       = 4;
  localparam int HT       = 2;
  localparam int AT       = 3;
  localparam int HOLD_CYC = HT * TD;
  localparam int TO_CYC   = AT * TD;
  localparam int MAXE     = 256;

  localparam logic [2:0] S_ASSERT = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

`ifdef RESET_SEQ_RETRY_EN
  localparam int MAX_RETRY = 3;
`else
  localparam int MAX_RETRY = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

  reset_sequencer #(
    .NUM_STAGES (NS),
    .SYNC_DEPTH (SD),
    .TICK_DIV   (TD),
    .HOLD_TICKS (HT),
    .ACK_TIMEOUT(AT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .seq  (bus)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int edgeNum = 0;
  int ackDelay [NS];
  int relCnt   [NS];
  int dropEdge  = 0;
  int dropStage = 0;
  bit noise     = 1'b0;

  logic [2:0]    expState [MAXE];
  logic [NS-1:0] expRstN  [MAXE];
  logic          expAll   [MAXE];
  logic          expFault [MAXE];

  task automatic checkEq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge %0d observed %0h expected %0h", tag, edgeNum, obs, exp);
    end
  endtask

  task automatic fill(input int from, input int upto, input logic [2:0] st,
                      input logic [NS-1:0] rn, input logic al, input logic fl);
    for (int e = from; e < upto && e < MAXE; e++) begin
      expState[e] = st;
      expRstN[e]  = rn;
      expAll[e]   = al;
      expFault[e] = fl;
    end
  endtask

  // Timeline of events: each stage is released HOLD_CYC edges after its hold starts and acks
  // ackDelay edges later, or times out TO_CYC edges after release.
  task automatic buildModel(input int len, input int dropAfter);
    int h, k, r, a, retries, runStart;
    logic [NS-1:0] rel;
    bit done;
    fill(1, SD + 1, S_ASSERT, '0, 1'b0, 1'b0);
    h = SD + 1; k = 0; rel = '0; retries = 0; runStart = 0; done = 1'b0; dropEdge = 0;
    while (!done) begin
      r = h + HOLD_CYC;
      fill(h, r, S_HOLD, rel, 1'b0, 1'b0);
      rel[k] = 1'b1;
      if (ackDelay[k] <= TO_CYC) begin
        a = r + ackDelay[k];
        fill(r, a, S_WAIT, rel, 1'b0, 1'b0);
        if (k == NS - 1) begin
          runStart = a;
          done     = 1'b1;
        end else begin
          k++;
          h = a;
        end
      end else begin
        fill(r, r + TO_CYC, S_WAIT, rel, 1'b0, 1'b0);
        if (retries < MAX_RETRY) begin
          retries++;
          rel = '0;
          k   = 0;
          h   = r + TO_CYC;
        end else begin
          fill(r + TO_CYC, len + 1, S_FAULT, '0, 1'b0, 1'b1);
          done = 1'b1;
        end
      end
    end
    if (runStart != 0) begin
      if (dropAfter > 0) begin
        dropEdge = runStart + dropAfter;
        fill(runStart, dropEdge, S_RUN, '1, 1'b1, 1'b0);
        fill(dropEdge, len + 1, S_FAULT, '0, 1'b0, 1'b1);
      end else begin
        fill(runStart, len + 1, S_RUN, '1, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic checkOutput();
    if (edgeNum < MAXE) begin
      checkEq("seq_state", 8'(bus.seq_state), 8'(expState[edgeNum]));
      checkEq("stage_reset_n", 8'(bus.stage_reset_n), 8'(expRstN[edgeNum]));
      checkEq("all_ready", 8'(bus.all_ready), 8'(expAll[edgeNum]));
      checkEq("fault", 8'(bus.fault), 8'(expFault[edgeNum]));
    end
  endtask

  // Released stages ack after their chosen delay; unreleased ones may toggle randomly.
  task automatic applyStimulus();
    logic [NS-1:0] v;
    v = '0;
    for (int k = 0; k < NS; k++) begin
      if (relCnt[k] == 0) v[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      else                v[k] = (relCnt[k] >= ackDelay[k]);
    end
    if (dropEdge != 0 && edgeNum == dropEdge - 1) v[dropStage] = 1'b0;
    bus.stage_ready = v;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    edgeNum++;
    checkOutput();
    for (int k = 0; k < NS; k++) begin
      relCnt[k] = bus.stage_reset_n[k] ? relCnt[k] + 1 : 0;
    end
    applyStimulus();
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkEq("async stage_reset_n", 8'(bus.stage_reset_n), 8'h00);
    checkEq("async seq_state", 8'(bus.seq_state), 8'h00);
    checkEq("async all_ready", 8'(bus.all_ready), 8'h00);
    checkEq("async fault", 8'(bus.fault), 8'h00);
    bus.stage_ready = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic runScenario(input int d0, input int d1, input int d2, input int dropAfter,
                             input int dropStg, input int len, input bit noiseEn);
    ackDelay[0] = d0;
    ackDelay[1] = d1;
    ackDelay[2] = d2;
    dropStage   = dropStg;
    noise       = noiseEn;
    buildModel(len, dropAfter);
    doReset();
    @(negedge clk);
    reset   = 1'b1;
    edgeNum = 0;
    for (int k = 0; k < NS; k++) relCnt[k] = 0;
    repeat (len) stepCycle();
  endtask

  initial begin
    bus.stage_ready = '0;
    for (int k = 0; k < NS; k++) relCnt[k] = 0;

    $display("[TB] tied ready: releases at edges 11/20/29, RUN at 30");
    runScenario(1, 1, 1, 0, 0, 40, 1'b0);

    $display("[TB] stage1 never ready: timeout after release at edge 20");
    runScenario(1, 1000, 1, 0, 0, 160, 1'b0);

    $display("[TB] reset pulled between edges 15 and 16, then full restart");
    runScenario(1, 1, 1, 0, 0, 15, 1'b0);
    runScenario(1, 1, 1, 0, 0, 40, 1'b0);

    $display("[TB] stage0 ready drop while running");
    runScenario(1, 1, 1, 5, 0, 45, 1'b0);

    $display("[TB] stage0 ready on the timeout edge");
    runScenario(TO_CYC, 1, 1, 0, 0, 60, 1'b0);

    $display("[TB] stage0 ready one edge too late");
    runScenario(TO_CYC + 1, 1, 1, 0, 0, 160, 1'b1);

    $display("[TB] randomised ack delays, drops and unreleased-stage noise");
    for (int i = 0; i < 8; i++) begin
      runScenario($urandom_range(1, TO_CYC + 2), $urandom_range(1, TO_CYC + 2),
                  $urandom_range(1, TO_CYC + 2), $urandom_range(0, 8),
                  $urandom_range(0, NS - 1), 250, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
